jesd204_tx_ilas_gen: RTL and testbench

Generates the JESD204B Initial Lane Alignment Sequence (ILAS) on every TX lane: four multiframes, each framed by /R/ and /A/, with the link configuration inserted in the second multiframe.
Sits directly downstream of the static ILAS configuration ROM. It drives that ROM's read port and consumes its registered per-lane 32-bit words.
Its output feeds the per-lane scrambler/8b10b path through the TX lane mux.

---
 rtl/jesd204_tx_pkg.sv | 17 +
 rtl/jesd204_tx_ilas_lane.sv | 59 +++++
 rtl/jesd204_tx_ilas_gen.sv | 165 ++++++++++++++++
 tb/tb_jesd204_tx_ilas_gen.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/jesd204_tx_pkg.sv
// JESD204B TX shared definitions: K-characters, ILAS framing, FSM encoding.
// Imported by the ILAS generator and its per-lane octet mux.
package jesd204_tx_pkg;

  localparam logic [7:0] K_R = 8'h1C;
  localparam logic [7:0] K_A = 8'h7C;
  localparam logic [7:0] K_Q = 8'h9C;

  localparam int ILAS_MULTIFRAMES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ILAS = 2'd1,
    DONE = 2'd2
  } ilas_state_t;

endpackage

// File: rtl/jesd204_tx_ilas_lane.sv
// One lane of ILAS octet generation: framing K-chars, config words, ramp.
// Position inputs describe the beat loaded into the output register.
module jesd204_tx_ilas_lane
  import jesd204_tx_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_emit,
  input  logic [1:0]  i_mf,
  input  logic [7:0]  i_beat,
  input  logic        i_last,
  input  logic [31:0] i_rom,
  output logic [31:0] o_data,
  output logic [3:0]  o_charisk
);

  logic [31:0] w_data;
  logic [3:0]  w_k;
  logic [31:0] r_data;
  logic [3:0]  r_k;

  always_comb begin
    w_data = '0;
    w_k    = '0;
    for (int b = 0; b < 4; b++) begin
      w_data[8*b +: 8] = {i_beat[5:0], 2'(b)};
    end
    if (i_mf == 2'd1 && i_beat < 8'd4) begin
      w_data = i_rom;
    end
    if (i_beat == 8'd0) begin
      w_data[7:0] = K_R;
      w_k[0]      = 1'b1;
    end
    // /Q/ displaces the first config octet slot in MF1
    if (i_mf == 2'd1 && i_beat == 8'd0) begin
      w_data[15:8] = K_Q;
      w_k[1]       = 1'b1;
    end
    if (i_last) begin
      w_data[31:24] = K_A;
      w_k[3]        = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !i_emit) begin
      r_data <= '0;
      r_k    <= '0;
    end else begin
      r_data <= w_data;
      r_k    <= w_k;
    end
  end

  assign o_data    = r_data;
  assign o_charisk = r_k;

endmodule

// File: rtl/jesd204_tx_ilas_gen.sv
// JESD204B TX ILAS generator: FSM, beat/multiframe counters, ROM read
// scheduling, and NUM_LANES lockstep lane octet muxes.
module jesd204_tx_ilas_gen
  import jesd204_tx_pkg::*;
#(
  parameter int NUM_LANES       = 1,
  parameter int DATA_PATH_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             cfg_beats_per_multiframe,
  input  logic                   ilas_start,
  output logic                   ilas_config_rd,
  output logic [1:0]             ilas_config_addr,
  input  logic [NUM_LANES*32-1:0] ilas_config_data,
  output logic [NUM_LANES*32-1:0] tx_data,
  output logic [NUM_LANES*4-1:0]  tx_charisk,
  output logic                   ilas_active,
  output logic                   ilas_done
);

  if (DATA_PATH_WIDTH != 4) begin : g_bad_dpw
    $error("jesd204_tx_ilas_gen: only DATA_PATH_WIDTH=4 is supported");
  end

  ilas_state_t r_state;
  ilas_state_t w_state_nxt;

  logic [1:0] r_mf;
  logic [7:0] r_beat;
  logic       r_rd;
  logic [1:0] r_addr;
  logic       r_active;
  logic       r_done;

  logic       w_emit;
  logic [1:0] w_nmf;
  logic [7:0] w_nbeat;
  logic       w_nlast;
  logic       w_rd;
  logic [1:0] w_addr;
  logic       w_done;

  wire [7:0] w_b = cfg_beats_per_multiframe;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_mf    <= '0;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mf    <= w_nmf;
      r_beat  <= w_nbeat;
    end
  end

  // State tracks the beat being loaded, one cycle ahead of tx_data
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (ilas_start) w_state_nxt = ILAS;
      ILAS: begin
        if (w_nmf == 2'(ILAS_MULTIFRAMES - 1) && w_nbeat == w_b)
          w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_emit  = 1'b0;
    w_nmf   = '0;
    w_nbeat = '0;
    w_done  = 1'b0;
    unique case (r_state)
      IDLE: w_emit = ilas_start;
      ILAS: begin
        w_emit = 1'b1;
        if (r_beat == w_b) begin
          w_nmf = r_mf + 2'd1;
        end else begin
          w_nmf   = r_mf;
          w_nbeat = r_beat + 8'd1;
        end
      end
      DONE:    w_done = 1'b1;
      default: w_emit = 1'b0;
    endcase
  end

  assign w_nlast = w_emit && (w_nbeat == w_b);

  // Read two beats ahead so the ROM word lands with MF1 beat k
  always_comb begin
    w_rd   = 1'b0;
    w_addr = '0;
    if (w_emit) begin
      unique case (1'b1)
        (w_nmf == 2'd0 && w_nbeat == w_b - 8'd1): begin
          w_rd   = 1'b1;
          w_addr = 2'd0;
        end
        (w_nmf == 2'd0 && w_nbeat == w_b): begin
          w_rd   = 1'b1;
          w_addr = 2'd1;
        end
        (w_nmf == 2'd1 && w_nbeat == 8'd0): begin
          w_rd   = 1'b1;
          w_addr = 2'd2;
        end
        (w_nmf == 2'd1 && w_nbeat == 8'd1): begin
          w_rd   = 1'b1;
          w_addr = 2'd3;
        end
        default: begin
          w_rd   = 1'b0;
          w_addr = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd     <= 1'b0;
      r_addr   <= '0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_rd     <= w_rd;
      r_addr   <= w_addr;
      r_active <= w_emit;
      r_done   <= w_done;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && ilas_start && r_state == IDLE) begin
      assert (cfg_beats_per_multiframe >= 8'd4)
        else $error("ilas_gen: beats per multiframe below 4");
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    jesd204_tx_ilas_lane u_lane (
      .clk       (clk),
      .reset     (reset),
      .i_emit    (w_emit),
      .i_mf      (w_nmf),
      .i_beat    (w_nbeat),
      .i_last    (w_nlast),
      .i_rom     (ilas_config_data[32*g +: 32]),
      .o_data    (tx_data[32*g +: 32]),
      .o_charisk (tx_charisk[4*g +: 4])
    );
  end

  assign ilas_config_rd   = r_rd;
  assign ilas_config_addr = r_addr;
  assign ilas_active      = r_active;
  assign ilas_done        = r_done;

endmodule

// File: tb/tb_jesd204_tx_ilas_gen.sv
// Self-checking bench for jesd204_tx_ilas_gen with a 2-lane ROM model
// and an octet-level reference of the ILAS sequence.
module tb_jesd204_tx_ilas_gen;

  localparam int NL = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [7:0]      cfg;
  logic            ilas_start;
  logic            rd;
  logic [1:0]      addr;
  logic [NL*32-1:0] rom_q;
  logic [NL*32-1:0] tx_data;
  logic [NL*4-1:0]  tx_k;
  logic            active;
  logic            done;

  logic [31:0] rom [NL][4];
  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  jesd204_tx_ilas_gen #(.NUM_LANES(NL), .DATA_PATH_WIDTH(4)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .cfg_beats_per_multiframe (cfg),
    .ilas_start               (ilas_start),
    .ilas_config_rd           (rd),
    .ilas_config_addr         (addr),
    .ilas_config_data         (rom_q),
    .tx_data                  (tx_data),
    .tx_charisk               (tx_k),
    .ilas_active              (active),
    .ilas_done                (done)
  );

  // 1-cycle ROM; garbage when not read so mis-timed capture is visible
  always @(posedge clk) begin
    for (int l = 0; l < NL; l++)
      rom_q[32*l +: 32] <= rd ? rom[l][addr] : $urandom;
  end

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    nvec++;
    assert (o === e)
      else begin
        nerr++;
        $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
  endtask

  function automatic void model_beat(input int b, input int mf, input int beat,
                                     input int lane, output logic [31:0] d,
                                     output logic [3:0] k);
    d = '0;
    k = '0;
    for (int j = 0; j < 4; j++) begin
      int o;
      logic [7:0] v;
      logic [31:0] w;
      o = 4*beat + j;
      v = 8'(o);
      if (o == 0) begin
        v = 8'h1C; k[j] = 1'b1;
      end else if (o == 4*b + 3) begin
        v = 8'h7C; k[j] = 1'b1;
      end else if (mf == 1 && o == 1) begin
        v = 8'h9C; k[j] = 1'b1;
      end else if (mf == 1 && o >= 2 && o <= 15) begin
        w = rom[lane][o/4];
        v = w[8*(o%4) +: 8];
      end
      d[8*j +: 8] = v;
    end
  endfunction

  task automatic check_cycle(input int t, input int b, input string tag);
    logic [63:0] ed;
    logic [7:0]  ek;
    logic [31:0] d;
    logic [3:0]  k;
    int len;
    bit act, erd;
    len = 4*(b+1);
    act = (t >= 1 && t <= len);
    ed = '0;
    ek = '0;
    if (act) begin
      for (int l = 0; l < NL; l++) begin
        model_beat(b, (t-1)/(b+1), (t-1)%(b+1), l, d, k);
        ed[32*l +: 32] = d;
        ek[4*l +: 4]   = k;
      end
    end
    erd = (t >= b && t <= b+3);
    chk($sformatf("%s t=%0d data", tag, t), 64'(tx_data), ed);
    chk($sformatf("%s t=%0d charisk", tag, t), 64'(tx_k), 64'(ek));
    chk($sformatf("%s t=%0d active", tag, t), 64'(active), 64'(act));
    chk($sformatf("%s t=%0d done", tag, t), 64'(done), 64'(t == len+1));
    chk($sformatf("%s t=%0d rd", tag, t), 64'(rd), 64'(erd));
    chk($sformatf("%s t=%0d addr", tag, t), 64'(addr), erd ? 64'(t-b) : 64'd0);
  endtask

  // Called in cycle T (just after an edge); pulses start and checks all beats
  task automatic run_seq(input int b, input int extra, input bit chain, input string tag);
    int len;
    len = 4*(b+1);
    cfg = 8'(b);
    ilas_start = 1'b1;
    for (int t = 1; t <= len+2; t++) begin
      @(posedge clk); #1;
      ilas_start = (t == extra) || (chain && t == len+1);
      check_cycle(t, b, tag);
      if (chain && t == len+1) return;
    end
  endtask

  task automatic idle_chk(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk($sformatf("%s i=%0d active", tag, i), 64'(active), 64'd0);
      chk($sformatf("%s i=%0d done", tag, i), 64'(done), 64'd0);
      chk($sformatf("%s i=%0d rd", tag, i), 64'(rd), 64'd0);
      chk($sformatf("%s i=%0d data", tag, i), 64'(tx_data), 64'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < NL; i++)
      for (int k = 0; k < 4; k++)
        rom[i][k] = {4'(i), 4'(k), 4'(i), 4'(k), 8'h5A, 4'h0, 4'(k)};
    reset = 1'b1;
    ilas_start = 1'b0;
    cfg = 8'd4;
    repeat (3) @(posedge clk);
    #1;
    chk("rst data", 64'(tx_data), 64'd0);
    chk("rst charisk", 64'(tx_k), 64'd0);
    chk("rst active", 64'(active), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst rd", 64'(rd), 64'd0);
    chk("rst addr", 64'(addr), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_seq(4, 8, 1'b1, "b4_ign");
    run_seq(4, 0, 1'b0, "b4_restart");
    idle_chk(3, "gap");

    cfg = 8'd4;
    ilas_start = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      @(posedge clk); #1;
      ilas_start = 1'b0;
      check_cycle(t, 4, "pre_rst");
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst data", 64'(tx_data), 64'd0);
    chk("midrst charisk", 64'(tx_k), 64'd0);
    chk("midrst active", 64'(active), 64'd0);
    chk("midrst rd", 64'(rd), 64'd0);
    chk("midrst addr", 64'(addr), 64'd0);
    idle_chk(25, "post_rst");
    run_seq(4, 0, 1'b0, "after_rst");

    run_seq(10, 0, 1'b0, "b10");

    for (int r = 0; r < 4; r++) begin
      int b;
      for (int i = 0; i < NL; i++)
        for (int k = 0; k < 4; k++)
          rom[i][k] = $urandom;
      b = $urandom_range(4, 14);
      idle_chk($urandom_range(1, 4), "rgap");
      run_seq(b, $urandom_range(2, 4*(b+1)), 1'b0, $sformatf("rnd%0d_b%0d", r, b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
